// File: rtl/led_shifter_pkg.sv
// Shared encodings for the LED shifter: operating modes and shift direction.
package led_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // MANUAL -> ROTATE -> BOUNCE -> MANUAL; the unused code 3 falls back to MANUAL.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_MANUAL: return MODE_ROTATE;
      MODE_ROTATE: return MODE_BOUNCE;
      default:     return MODE_MANUAL;
    endcase
  endfunction

  function automatic dir_e flip_dir(input dir_e d);
    return (d == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  // Held at zero while disabled so every enable starts a full period.
  always_ff @(posedge clk) begin
    if (sync_reset || clear || !enable || (count_q == LAST)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/led_shifter_2.sv
// LED pattern register with manual shifting, automatic rotation and bouncing,
// driven by one-cycle button pulses and a divided auto-step tick.
module led_shifter_2
  import led_shifter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             button0_re,
  input  logic             button1_re,
  input  logic             button2_re,
  input  logic             button3_re,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       mode,
  output logic             dir
);

  mode_e            mode_q;
  dir_e             dir_q;
  logic [WIDTH-1:0] out_q;
  logic             tick;
  logic             auto_en;

  assign auto_en = (mode_q != MODE_MANUAL);

  // A mode change restarts the step period from zero.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk        (clk),
    .sync_reset (sync_reset),
    .enable     (auto_en),
    .clear      (button2_re),
    .tick       (tick)
  );

  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v, input dir_e d);
    return (d == DIR_RIGHT) ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input dir_e d,
                                                input logic b);
    return (d == DIR_RIGHT) ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
  endfunction

  // Priority: mode > direction (may combine with a ROTATE tick) > tick > manual shift.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      out_q  <= '0;
      mode_q <= MODE_MANUAL;
      dir_q  <= DIR_LEFT;
    end else if (button2_re) begin
      mode_q <= next_mode(mode_q);
      if ((mode_q == MODE_MANUAL) && (out_q == '0)) begin
        out_q <= {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else if (button3_re) begin
      dir_q <= flip_dir(dir_q);
      if (tick && (mode_q == MODE_ROTATE)) begin
        out_q <= rotate(out_q, flip_dir(dir_q));
      end
    end else if (tick) begin
      case (mode_q)
        MODE_ROTATE: out_q <= rotate(out_q, dir_q);
        MODE_BOUNCE: begin
          if ((dir_q == DIR_LEFT) && out_q[WIDTH-1]) begin
            dir_q <= DIR_RIGHT;
          end else if ((dir_q == DIR_RIGHT) && out_q[0]) begin
            dir_q <= DIR_LEFT;
          end else begin
            out_q <= rotate(out_q, dir_q);
          end
        end
        default: ;
      endcase
    end else if ((mode_q == MODE_MANUAL) && (button0_re || button1_re)) begin
      out_q <= shift_in(out_q, dir_q, !button0_re);
    end
  end

  assign out  = out_q;
  assign mode = mode_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_led_shifter_2.sv
// Directed bench for led_shifter_2 (WIDTH=8, TICK_DIV=4) with hand-computed expectations.
module tb_led_shifter_2;

  localparam int WIDTH    = 8;
  localparam int TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             sync_reset = 1'b1;
  logic             button0_re = 1'b0;
  logic             button1_re = 1'b0;
  logic             button2_re = 1'b0;
  logic             button3_re = 1'b0;
  logic [WIDTH-1:0] out;
  logic [1:0]       mode;
  logic             dir;

  int checks   = 0;
  int failures = 0;

  led_shifter_2 #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .button0_re (button0_re),
    .button1_re (button1_re),
    .button2_re (button2_re),
    .button3_re (button3_re),
    .out        (out),
    .mode       (mode),
    .dir        (dir)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // All driver tasks start and end on a falling edge.
  task automatic do_reset();
    sync_reset = 1'b1;
    repeat (2) @(negedge clk);
    sync_reset = 1'b0;
  endtask

  task automatic pulse(input logic b0, input logic b1, input logic b2, input logic b3);
    button0_re = b0;
    button1_re = b1;
    button2_re = b2;
    button3_re = b3;
    @(negedge clk);
    button0_re = 1'b0;
    button1_re = 1'b0;
    button2_re = 1'b0;
    button3_re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_out", 32'(out), 32'h00);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_dir", 32'(dir), 32'd0);

    // Manual left shifts
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    check("manual_b1b1b0", 32'(out), 32'h06);

    // Toggle direction, then shift a 1 in at the MSB
    pulse(0, 0, 0, 1);
    check("b3_dir", 32'(dir), 32'd1);
    check("b3_out_kept", 32'(out), 32'h06);
    pulse(0, 1, 0, 0);
    check("manual_right_b1", 32'(out), 32'h83);

    // ROTATE entry from zero seeds the LSB
    do_reset();
    pulse(0, 0, 1, 0);
    check("rot_entry_mode", 32'(mode), 32'd1);
    check("rot_entry_seed", 32'(out), 32'h01);
    pulse(0, 1, 0, 0);
    idle(2);
    check("rot_b1_ignored_no_tick", 32'(out), 32'h01);
    idle(1);
    check("rot_tick1", 32'(out), 32'h02);
    idle(4);
    check("rot_tick2", 32'(out), 32'h04);
    idle(20);
    check("rot_tick7", 32'(out), 32'h80);
    idle(4);
    check("rot_wrap", 32'(out), 32'h01);

    // BOUNCE from 0x40, dir left
    do_reset();
    pulse(0, 1, 0, 0);
    repeat (6) pulse(1, 0, 0, 0);
    check("bounce_setup", 32'(out), 32'h40);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    check("bounce_mode", 32'(mode), 32'd2);
    idle(4);
    check("bounce_t1_out", 32'(out), 32'h80);
    idle(4);
    check("bounce_t2_out", 32'(out), 32'h80);
    check("bounce_t2_dir", 32'(dir), 32'd1);
    idle(4);
    check("bounce_t3_out", 32'(out), 32'h40);
    idle(24);
    check("bounce_low_out", 32'(out), 32'h01);
    check("bounce_low_dir", 32'(dir), 32'd1);
    idle(4);
    check("bounce_lsb_out", 32'(out), 32'h01);
    check("bounce_lsb_dir", 32'(dir), 32'd0);
    idle(4);
    check("bounce_resume", 32'(out), 32'h02);

    // Same-cycle b2+b1 in MANUAL: mode wins, no shift
    do_reset();
    pulse(0, 1, 0, 0);
    pulse(0, 1, 1, 0);
    check("b2b1_mode", 32'(mode), 32'd1);
    check("b2b1_out", 32'(out), 32'h01);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    check("mode_wrap", 32'(mode), 32'd0);
    check("mode_wrap_out", 32'(out), 32'h01);

    // b3 on the tick cycle in ROTATE rotates with the new direction
    pulse(0, 0, 1, 0);
    idle(3);
    pulse(0, 0, 0, 1);
    check("b3_tick_dir", 32'(dir), 32'd1);
    check("b3_tick_out", 32'(out), 32'h80);

    // Reset mid-ROTATE
    do_reset();
    pulse(0, 1, 0, 0);
    repeat (4) pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    check("midrst_setup", 32'(out), 32'h10);
    idle(2);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    check("midrst_out", 32'(out), 32'h00);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_dir", 32'(dir), 32'd0);
    idle(4);
    check("midrst_no_tick", 32'(out), 32'h00);
    pulse(0, 0, 1, 0);
    idle(3);
    check("midrst_restart_hold", 32'(out), 32'h01);
    idle(1);
    check("midrst_restart_tick", 32'(out), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_shifter_2.md
LED_SHIFTER_2 -- requirements
Module: led_shifter_2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: LED register width, legal range 2..32.
REQ-002 The block SHALL have parameter TICK_DIV, default 25000000: clk cycles per automatic step, minimum 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port sync_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port button0_re, input, 1 bit: one-cycle pulse, shift in 0 (MANUAL only).
REQ-006 The block SHALL have port button1_re, input, 1 bit: one-cycle pulse, shift in 1 (MANUAL only).
REQ-007 The block SHALL have port button2_re, input, 1 bit: one-cycle pulse, advance mode.
REQ-008 The block SHALL have port button3_re, input, 1 bit: one-cycle pulse, toggle direction.
REQ-009 The block SHALL have port out, output, WIDTH bits: the LED pattern register.
REQ-010 The block SHALL have port mode, output, 2 bits: current mode, where 0=MANUAL, 1=ROTATE, 2=BOUNCE.
REQ-011 The block SHALL have port dir, output, 1 bit: 0=left (toward MSB), 1=right (toward LSB).

Function
REQ-012 All outputs SHALL be registered; each accepted event SHALL be visible on out/mode/dir one clk after its pulse.
REQ-013 Mode SHALL advance on button2_re: MANUAL->ROTATE->BOUNCE->MANUAL. Value 3 is unreachable.
REQ-014 Priority for same-cycle pulses SHALL be button2_re > button3_re > button0_re > button1_re; lower-priority pulses in that cycle are discarded, with one exception: button3_re together with an auto tick per REQ-019.
REQ-015 In MANUAL, button0_re/button1_re SHALL shift out by one in direction dir, inserting 0/1 at the LSB (left) or MSB (right); bits shifted out are lost.
REQ-016 In ROTATE/BOUNCE, button0_re and button1_re SHALL be ignored.
REQ-017 A prescaler SHALL count 0..TICK_DIV-1 only in ROTATE/BOUNCE and wrap to 0. Tick = count equal to TICK_DIV-1. The prescaler is held at 0 in MANUAL.
REQ-018 Every mode change SHALL clear the prescaler; no step occurs in the mode-change cycle.
REQ-019 ROTATE tick: out SHALL rotate by one in dir, with no bit loss. If button3_re occurs in the tick cycle, the rotation SHALL use the toggled direction.
REQ-020 BOUNCE tick behaviour SHALL be:
- If dir=left and out[WIDTH-1]=1: dir becomes right and out is unchanged.
- Else if dir=right and out[0]=1: dir becomes left and out is unchanged.
- Otherwise: rotate as in ROTATE.
REQ-021 Entering ROTATE from MANUAL with out==0 SHALL load out=1 (LSB seed) in the same update; otherwise out is kept.
REQ-022 Entering BOUNCE or MANUAL SHALL keep out and dir unchanged.
REQ-023 button3_re SHALL toggle dir in every mode.

Reset
REQ-024 While sync_reset=1 at a clk edge, the block SHALL set out=0, mode=MANUAL, dir=0 and prescaler=0, ignoring all buttons.
REQ-025 A reset asserted mid-operation SHALL abort any pending tick; after release the prescaler SHALL restart from 0.

Structure
REQ-026 Mode encodings (MANUAL/ROTATE/BOUNCE) and the direction encoding SHALL live in shared package led_shifter_pkg.
REQ-027 The prescaler SHALL be sub-module tick_prescaler with the following properties:
- Parameter: TICK_DIV.
- Inputs: clk, sync_reset, enable, clear.
- Output: 1-bit tick.
- Counter width: clog2(TICK_DIV).
REQ-028 The mode/direction/pattern logic SHALL be a single registered next-state process in led_shifter_2.

Verification (WIDTH=8, TICK_DIV=4)
REQ-029 Reset, MANUAL, dir=0, pulses b1,b1,b0 -> out=0x06.
REQ-030 From out=0x06, pulse b3 then b1 -> dir=1, out=0x83.
REQ-031 out=0x00, pulse b2 -> mode=1, out=0x01; 4 clks later out=0x02; 8 clks later out=0x04; an 8th tick from 0x80 -> 0x01.
REQ-032 BOUNCE, out=0x40, dir=0:
- Ticks give 0x80, then 0x80 with dir=1, then 0x40.
- With out=0x01, dir=1: next tick dir=0, out=0x01.
REQ-033 Same-cycle b2+b1 in MANUAL -> mode=1, pattern is not shifted by b1. Same-cycle b3+tick in ROTATE -> rotation uses the new dir.
REQ-034 sync_reset for one cycle mid-ROTATE with out=0x10 -> out=0, mode=0, dir=0; after release, no tick for the following 4 clks.
